// File: rtl/sensor_raw_framer_if.sv
// Sensor-to-framer stream bundle: vsync/href-qualified raw pixels in, line-framed pixels out.
// master = framer side, slave = sensor/consumer environment side.
interface sensor_raw_framer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] sens_data;
  logic                  sens_href;
  logic                  sens_vsync;
  logic [DATA_WIDTH-1:0] raw_data;
  logic                  raw_valid;
  logic                  raw_sop;
  logic                  raw_eop;

  modport master (
    input  sens_data, sens_href, sens_vsync,
    output raw_data, raw_valid, raw_sop, raw_eop
  );

  modport slave (
    output sens_data, sens_href, sens_vsync,
    input  raw_data, raw_valid, raw_sop, raw_eop
  );
endinterface

// File: rtl/sensor_raw_framer.sv
// Frames a vsync/href sensor stream into H_ACTIVE x V_ACTIVE raw lines with sticky geometry errors.
// Define FRAMER_PAD_EN to pad short lines to H_ACTIVE by replicating the last captured pixel.
module sensor_raw_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720
) (
  input  logic                clk,
  input  logic                reset_n,
  sensor_raw_framer_if.master bus,
  input  logic                err_clr,
  output logic [11:0]         line_idx,
  output logic [3:0]          err
);

  localparam int CW = $clog2(H_ACTIVE) + 1;

`ifdef FRAMER_PAD_EN
  typedef enum logic [2:0] {IDLE, WAIT_LINE, ACTIVE, PAD, FRAME_DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, WAIT_LINE, ACTIVE, FRAME_DONE} state_t;
`endif

  state_t                state;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_href;
  logic                  s1_vsync;
  logic                  s1_vsync_d;
  logic [CW-1:0]         pix_cnt;
  logic                  drop_line;
`ifdef FRAMER_PAD_EN
  logic [CW-1:0]         pad_left;
`endif

  logic          vsync_rise;
  logic          take_pix;
  logic [CW-1:0] cur_idx;
  logic [11:0]   cur_line;
  logic          end_full;
  logic          eop_now;
  logic          last_line;
  logic          frame_cut;

  // End-of-line decisions look one sample ahead at the unregistered sensor inputs.
  always_comb begin
    vsync_rise = s1_vsync && !s1_vsync_d;
    take_pix   = (state == ACTIVE) ||
                 ((state == WAIT_LINE) && !vsync_rise && !drop_line && s1_href);
    cur_idx    = (state == ACTIVE) ? pix_cnt : '0;
    cur_line   = (state == ACTIVE) ? line_idx : line_idx + 12'd1;
    end_full   = (cur_idx == CW'(H_ACTIVE - 1));
    eop_now    = end_full || !bus.sens_href || bus.sens_vsync;
    last_line  = (cur_line == 12'(V_ACTIVE));
    frame_cut  = bus.sens_vsync && !(end_full && last_line);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      s1_data       <= '0;
      s1_href       <= 1'b0;
      s1_vsync      <= 1'b0;
      s1_vsync_d    <= 1'b0;
      pix_cnt       <= '0;
      drop_line     <= 1'b0;
      line_idx      <= '0;
      err           <= '0;
      bus.raw_data  <= '0;
      bus.raw_valid <= 1'b0;
      bus.raw_sop   <= 1'b0;
      bus.raw_eop   <= 1'b0;
`ifdef FRAMER_PAD_EN
      pad_left      <= '0;
`endif
    end else begin
      s1_data       <= bus.sens_data;
      s1_href       <= bus.sens_href;
      s1_vsync      <= bus.sens_vsync;
      s1_vsync_d    <= s1_vsync;
      bus.raw_valid <= 1'b0;
      bus.raw_sop   <= 1'b0;
      bus.raw_eop   <= 1'b0;
      // Clear first so any error flagged below in the same cycle survives.
      if (err_clr) err <= '0;

      case (state)
        IDLE: begin
          if (vsync_rise) begin
            state    <= WAIT_LINE;
            line_idx <= '0;
          end
        end
        WAIT_LINE: begin
          if (vsync_rise) begin
            if (line_idx < 12'(V_ACTIVE)) err[2] <= 1'b1;
            line_idx  <= '0;
            drop_line <= 1'b0;
          end else if (drop_line && !s1_href) begin
            drop_line <= 1'b0;
          end
        end
        ACTIVE: ;
`ifdef FRAMER_PAD_EN
        PAD: begin
          bus.raw_valid <= 1'b1;
          bus.raw_eop   <= (pad_left == CW'(1));
          pad_left      <= pad_left - 1'b1;
          if (s1_href) begin
            err[3]    <= 1'b1;
            drop_line <= 1'b1;
          end
          if (pad_left == CW'(1))
            state <= (line_idx == 12'(V_ACTIVE)) ? FRAME_DONE : WAIT_LINE;
        end
`endif
        FRAME_DONE: begin
          if (vsync_rise) begin
            state     <= WAIT_LINE;
            line_idx  <= '0;
            drop_line <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (take_pix) begin
        bus.raw_valid <= 1'b1;
        bus.raw_data  <= s1_data;
        bus.raw_sop   <= (state == WAIT_LINE);
        line_idx      <= cur_line;
        if (!eop_now) begin
          state   <= ACTIVE;
          pix_cnt <= cur_idx + 1'b1;
        end else begin
          pix_cnt <= '0;
          if (frame_cut) begin
            bus.raw_eop <= 1'b1;
            err[2]      <= 1'b1;
            line_idx    <= '0;
            state       <= WAIT_LINE;
          end else begin
            if (!end_full) begin
              err[0] <= 1'b1;
            end else if (bus.sens_href) begin
              err[1]    <= 1'b1;
              drop_line <= 1'b1;
            end
            state <= last_line ? FRAME_DONE : WAIT_LINE;
`ifdef FRAMER_PAD_EN
            bus.raw_eop <= end_full;
            if (!end_full) begin
              state    <= PAD;
              pad_left <= CW'(H_ACTIVE - 1) - cur_idx;
            end
`else
            bus.raw_eop <= 1'b1;
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sensor_raw_framer.sv
// Self-checking bench for sensor_raw_framer (H_ACTIVE=8, V_ACTIVE=4); builds with or without FRAMER_PAD_EN.
module tb_sensor_raw_framer;

  localparam int DW = 8;
  localparam int H  = 8;
  localparam int V  = 4;

  logic        clk;
  logic        reset_n;
  logic        err_clr;
  logic [11:0] line_idx;
  logic [3:0]  err;

  sensor_raw_framer_if #(.DATA_WIDTH(DW)) bus();

  sensor_raw_framer #(
    .DATA_WIDTH(DW),
    .H_ACTIVE  (H),
    .V_ACTIVE  (V)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .err_clr (err_clr),
    .line_idx(line_idx),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  typedef struct {
    logic        vsync;
    int          n_pix;
    logic [3:0]  exp_err;
    logic [11:0] exp_line;
    logic        clr_after;
  } step_t;

  beat_t         exp_q[$];
  int            n_chk  = 0;
  int            n_fail = 0;
  logic          sb_off = 1'b0;
  logic [DW-1:0] pix_val = '0;
  step_t         steps[12];

  // Output beats are compared against the queue on the falling edge.
  always @(negedge clk) begin
    if (bus.raw_valid === 1'b1 && !sb_off) begin
      beat_t act;
      beat_t e;
      act = '{bus.raw_data, bus.raw_sop, bus.raw_eop};
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got data=%0d sop=%0b eop=%0b, required no raw_valid",
                 act.data, act.sop, act.eop);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL beat: got data=%0d sop=%0b eop=%0b, required data=%0d sop=%0b eop=%0b",
                   act.data, act.sop, act.eop, e.data, e.sop, e.eop);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic gap(input int n);
    bus.sens_href = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_pix(input logic push, input logic sop, input logic eop);
    bus.sens_href = 1'b1;
    bus.sens_data = pix_val;
    if (push) exp_q.push_back('{pix_val, sop, eop});
    pix_val = pix_val + 1'b1;
    tick();
  endtask

  // cut: the line is ended by vsync, which suppresses padding.
  task automatic drive_line(input int n, input logic emit, input logic cut);
    int            kept;
    logic [DW-1:0] last;
    logic          padded;
    kept   = (n > H) ? H : n;
    last   = '0;
    padded = 1'b0;
`ifdef FRAMER_PAD_EN
    padded = emit && !cut && (kept < H);
`endif
    for (int i = 0; i < n; i++) begin
      last = pix_val;
      drive_pix(emit && (i < H), i == 0, (i == kept - 1) && !padded);
    end
    bus.sens_href = 1'b0;
    if (padded)
      for (int j = kept; j < H; j++) exp_q.push_back('{last, 1'b0, j == H - 1});
  endtask

  task automatic pulse_vsync();
    bus.sens_href  = 1'b0;
    bus.sens_vsync = 1'b1;
    tick();
    tick();
    bus.sens_vsync = 1'b0;
    gap(3);
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_after_clr", 32'(err), 32'h0);
  endtask

  initial begin
    steps[0]  = '{1'b1, 8,  4'b0000, 12'd1, 1'b0};
    steps[1]  = '{1'b0, 8,  4'b0000, 12'd2, 1'b0};
    steps[2]  = '{1'b0, 8,  4'b0000, 12'd3, 1'b0};
    steps[3]  = '{1'b0, 8,  4'b0000, 12'd4, 1'b0};
    steps[4]  = '{1'b1, 8,  4'b0000, 12'd1, 1'b0};
    steps[5]  = '{1'b0, 10, 4'b0010, 12'd2, 1'b0};
    steps[6]  = '{1'b0, 8,  4'b0010, 12'd3, 1'b0};
    steps[7]  = '{1'b0, 8,  4'b0010, 12'd4, 1'b1};
    steps[8]  = '{1'b1, 5,  4'b0001, 12'd1, 1'b0};
    steps[9]  = '{1'b0, 8,  4'b0001, 12'd2, 1'b0};
    steps[10] = '{1'b0, 8,  4'b0001, 12'd3, 1'b0};
    steps[11] = '{1'b0, 8,  4'b0001, 12'd4, 1'b1};

    reset_n        = 1'b0;
    err_clr        = 1'b0;
    bus.sens_data  = '0;
    bus.sens_href  = 1'b0;
    bus.sens_vsync = 1'b0;
    tick();
    tick();
    tick();
    check("rst_raw_valid", 32'(bus.raw_valid), 32'h0);
    check("rst_raw_sop",   32'(bus.raw_sop),   32'h0);
    check("rst_raw_eop",   32'(bus.raw_eop),   32'h0);
    check("rst_raw_data",  32'(bus.raw_data),  32'h0);
    check("rst_line_idx",  32'(line_idx),      32'h0);
    check("rst_err",       32'(err),           32'h0);
    reset_n = 1'b1;
    tick();

    // Lines before the first vsync must be ignored.
    drive_line(8, 1'b0, 1'b0);
    gap(4);
    drive_line(8, 1'b0, 1'b0);
    gap(4);
    check("presync_line_idx", 32'(line_idx), 32'h0);
    check("presync_err",      32'(err),      32'h0);

    pix_val = '0;
    foreach (steps[k]) begin
      if (steps[k].vsync) begin
        pulse_vsync();
        check("vsync_line_idx", 32'(line_idx), 32'h0);
      end
      drive_line(steps[k].n_pix, 1'b1, 1'b0);
      gap(4);
      check("step_line_idx", 32'(line_idx), 32'(steps[k].exp_line));
      check("step_err",      32'(err),      32'(steps[k].exp_err));
      if (steps[k].clr_after) clear_errors();
    end

`ifdef FRAMER_PAD_EN
    // Short padded line overrun by an early href: the next line is dropped whole.
    pulse_vsync();
    drive_line(2, 1'b1, 1'b0);
    gap(2);
    drive_line(8, 1'b0, 1'b0);
    gap(4);
    drive_line(8, 1'b1, 1'b0);
    gap(4);
    check("overrun_line_idx", 32'(line_idx), 32'd2);
    check("overrun_err",      32'(err),      32'b1001);
    drive_line(8, 1'b1, 1'b0);
    gap(4);
    drive_line(8, 1'b1, 1'b0);
    gap(4);
    check("overrun_frame_end", 32'(line_idx), 32'd4);
    clear_errors();
`endif

    // vsync arriving right after the third pixel of line 2.
    pulse_vsync();
    drive_line(8, 1'b1, 1'b0);
    gap(4);
    drive_line(3, 1'b1, 1'b1);
    bus.sens_vsync = 1'b1;
    tick();
    tick();
    bus.sens_vsync = 1'b0;
    gap(4);
    check("cut_err",      32'(err),      32'b0100);
    check("cut_line_idx", 32'(line_idx), 32'h0);
    drive_line(8, 1'b1, 1'b0);
    gap(4);
    check("restart_line_idx", 32'(line_idx), 32'd1);
    check("restart_err",      32'(err),      32'b0100);
    clear_errors();

    // One-cycle reset in the middle of a line.
    drive_line(1, 1'b1, 1'b0);
    gap(4);
    sb_off = 1'b1;
    for (int i = 0; i < 3; i++) drive_pix(1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    drive_pix(1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    check("midrst_raw_valid", 32'(bus.raw_valid), 32'h0);
    check("midrst_raw_sop",   32'(bus.raw_sop),   32'h0);
    check("midrst_raw_eop",   32'(bus.raw_eop),   32'h0);
    check("midrst_raw_data",  32'(bus.raw_data),  32'h0);
    check("midrst_line_idx",  32'(line_idx),      32'h0);
    sb_off = 1'b0;
    for (int i = 0; i < 4; i++) drive_pix(1'b0, 1'b0, 1'b0);
    gap(4);
    check("postrst_line_idx", 32'(line_idx), 32'h0);
    check("postrst_err",      32'(err),      32'h0);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
